// File: rtl/alu_tx_pkg.sv
// alu_tx_pkg: shared op codes, FSM states and ASCII helpers for alu_result_tx.
package alu_tx_pkg;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_INV} op_e;
    typedef enum logic [2:0] {IDLE, CALC, LOAD, START, WAIT_HI, WAIT_LO} state_e;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; ADD/SUB wrap, shifts use the low log2(WIDTH) bits of B.
module alu_core
    import alu_tx_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);
    localparam int SW = $clog2(WIDTH);
    logic [SW-1:0] w_sh;
    assign w_sh = i_b[SW-1:0];
    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SHL:  o_result = i_a << w_sh;
            OP_SHR:  o_result = i_a >> w_sh;
            default: o_err    = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_result_tx.sv
// alu_result_tx: computes an ALU result on trigger and streams it to a UART byte by byte.
// Define ALU_RESULT_TX_ASCII_EN to send uppercase hex ASCII followed by CR LF instead of raw bytes.
module alu_result_tx
    import alu_tx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic [OPW-1:0]   operacion,
    input  logic             trigger,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy,
    output logic             done,
    output logic             overrun
);
    localparam int ND = WIDTH / 4;
`ifdef ALU_RESULT_TX_ASCII_EN
    localparam int NB = ND + 2;
`else
    localparam int NB = WIDTH / 8;
`endif
    localparam int CW = $clog2(NB + 1);

    state_e           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, w_res;
    logic [OPW-1:0]   r_op;
    logic [2:0]       w_code;
    logic             w_err, w_last;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       w_byte;

    // Codes beyond the 3-bit range are folded onto the invalid code.
    assign w_code  = (|(r_op >> 3)) ? 3'd7 : r_op[2:0];
    assign w_last  = (r_cnt == CW'(NB - 1));
    assign overrun = trigger && (r_state != IDLE);

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (op_e'(w_code)),
        .o_result (w_res),
        .o_err    (w_err)
    );

`ifdef ALU_RESULT_TX_ASCII_EN
    logic [3:0] w_nib;
    assign w_nib  = 4'(result >> (4 * (ND - 1 - int'(r_cnt))));
    assign w_byte = (int'(r_cnt) < ND) ? hex_ascii(w_nib) : ((int'(r_cnt) == ND) ? CR : LF);
`else
    assign w_byte = 8'(result >> (8 * (NB - 1 - int'(r_cnt))));
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = trigger ? CALC : IDLE;
            CALC:    w_next = LOAD;
            LOAD:    w_next = START;
            START:   w_next = tx_busy ? START : WAIT_HI;
            WAIT_HI: w_next = tx_busy ? WAIT_LO : WAIT_HI;
            WAIT_LO: w_next = tx_busy ? WAIT_LO : (w_last ? IDLE : LOAD);
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            result   <= '0;
            err      <= 1'b0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= (r_state == START) && !tx_busy;
            done     <= (r_state == WAIT_LO) && !tx_busy && w_last;
            if (r_state == IDLE && trigger) begin
                r_a  <= OP_A;
                r_b  <= OP_B;
                r_op <= operacion;
                busy <= 1'b1;
            end
            if (r_state == CALC) begin
                result <= w_res;
                err    <= w_err;
                r_cnt  <= '0;
            end
            if (r_state == LOAD) tx_data <= w_byte;
            if (r_state == WAIT_LO && !tx_busy) begin
                if (w_last) busy  <= 1'b0;
                else        r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule
